cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Line refill/writeback sequencer sitting directly behind the direct-mapped tag arbiter (`tag_arbiter_dm`). It consumes `line_miss`/`replace_dirty` and drives the arbiter's `line_refill`, `refill_tag` and `writeback_ok`. It moves whole cache lines between the cache data RAM and a single-word request/acknowledge memory bus. There is one outstanding miss at a time; the core stalls while `busy` is high.

## Interface
- ENTRY_NUM, 16, cache lines; must match arbiter
- ENTRYSEL_WID, clog2(ENTRY_NUM) (min 1), line index width
- TAG_WID, 14, tag width
- LINE_WORDS, 8, words per line, power of two ≥2
- OFF_WID, clog2(LINE_WORDS), word offset width
- DATA_WID, 32, word width
- WBACK_ENABLE, 1'b0, enables dirty writeback path; must match arbiter
- Memory address width MA = TAG_WID+ENTRYSEL_WID+OFF_WID (word address)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- line_miss  in  1  miss from arbiter
- replace_dirty  in  1  victim line dirty
- address_tag  in  TAG_WID  requested tag
- address_ent  in  ENTRYSEL_WID  requested line index
- victim_tag  in  TAG_WID  tag currently stored at address_ent (tag RAM read port)
- line_refill  out  1  one-cycle pulse: line filled, arbiter commits tag/valid
- refill_tag  out  TAG_WID  tag to commit; valid with line_refill
- writeback_ok  out  1  one-cycle pulse: victim written back
- busy  out  1  controller not IDLE
- cmem_addr  out  ENTRYSEL_WID+OFF_WID  data RAM word address {ent, off}
- cmem_re  out  1  data RAM read; data valid on cmem_rdata next cycle
- cmem_we  out  1  data RAM write
- cmem_wdata  out  DATA_WID  write data
- cmem_rdata  in  DATA_WID  read data
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  MA  word address
- mem_wdata  out  DATA_WID  write data
- mem_rdata  in  DATA_WID  read data, valid with mem_ack
- mem_ack  in  1  completes current word

## Operation
- States: IDLE, WB_RD, WB_WR, WB_DONE, FILL, FILL_DONE.
- IDLE: on line_miss, capture address_tag→ctag, address_ent→cent, victim_tag→vtag, and clear off to 0. Go to WB_RD if replace_dirty&WBACK_ENABLE, else FILL.
- WB_RD: cmem_re=1, cmem_addr={cent,off}. Go to WB_WR.
- WB_WR: on entry, latch cmem_rdata→mem_wdata. mem_req=1, mem_we=1, mem_addr={vtag,cent,off}. On mem_ack: if off==LINE_WORDS-1 go to WB_DONE, else off+1 and go to WB_RD.
- WB_DONE: writeback_ok=1 for one cycle, off←0. Go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={ctag,cent,off}. On mem_ack, same cycle: cmem_we=1, cmem_addr={cent,off}, cmem_wdata=mem_rdata. Last word goes to FILL_DONE, else off+1.
- FILL_DONE: line_refill=1, refill_tag=ctag. Go to IDLE.
- The core holds address_tag/address_ent stable from miss until line_refill. The arbiter indexes by its own address_ent.
- The offset counter wraps only via explicit reset to 0. No modular wrap is used.
- line_miss/replace_dirty are ignored outside IDLE.
- mem_ack with mem_req low is ignored.
- With WBACK_ENABLE=0, WB_* states are unreachable and writeback_ok is constant 0.

## Timing
- Reset values: all outputs 0, state IDLE, off 0. Asserting rst mid-transfer drops mem_req immediately (asynchronously). The partially written line stays invalid because no line_refill is issued.
- Zero-wait bus (ack in the same cycle as req): miss sampled in cycle 0, FILL in cycles 1..LINE_WORDS, line_refill in cycle LINE_WORDS+1, IDLE in cycle LINE_WORDS+2. The arbiter's line_miss is already low then, so there is no retrigger.
- Writeback: 2 cycles per word minimum, plus 1 cycle for WB_DONE.
- mem_req, mem_we, mem_addr and mem_wdata stay stable while mem_req=1 && !mem_ack.
- All outputs are decoded from registered state/counters. Exception: cmem_we/cmem_wdata in FILL follow mem_ack/mem_rdata combinationally.

## Structure
- Shared package cache_pkg: state enum encoding, a function building the word address {tag,ent,off}, and OFF_WID derivation.
- Single module, no sub-module; the offset counter is inline.

## Test plan
- Clean miss, LINE_WORDS=8, zero-wait ack, tag 0x155, ent 3 → mem_addr walks {0x155,3,0..7}; 8 cmem writes; line_refill pulse in cycle 9 with refill_tag=0x155.
- Ack delayed 3 cycles per word → mem_req/mem_addr held stable; total fill 33 cycles; data RAM words match bus data.
- WBACK_ENABLE=1, dirty victim vtag 0x0AA, ent 5 → 8 bus writes to {0x0AA,5,0..7} with cmem data, then writeback_ok pulse, then fill from the new tag.
- Async rst low at fill word 4 → mem_req=0 immediately, busy=0, no line_refill; next miss restarts at off 0.
- Spurious mem_ack in IDLE and replace_dirty=1 with WBACK_ENABLE=0 → no state change; fill only, writeback_ok stays 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the line refill/writeback sequencer: FSM state
// encoding, width derivation and the {tag, ent, off} word address builder.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WB_RD     = 3'd1,
        ST_WB_WR     = 3'd2,
        ST_WB_DONE   = 3'd3,
        ST_FILL      = 3'd4,
        ST_FILL_DONE = 3'd5
    } state_e;

    // Index width for n items, never below one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Word address {tag, ent, off}; callers cast the result to their width.
    function automatic logic [63:0] word_addr(input logic [63:0] tag,
                                              input logic [63:0] ent,
                                              input logic [63:0] off,
                                              input int          ent_wid,
                                              input int          off_wid);
        return (tag << (ent_wid + off_wid)) | (ent << off_wid) | off;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Line refill/writeback sequencer behind the direct-mapped tag arbiter.
// Moves a whole line between the data RAM and a single-word req/ack bus,
// optionally writing back a dirty victim first. One miss at a time.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ENTRY_NUM    = 16,
    parameter int ENTRYSEL_WID = clog2_min1(ENTRY_NUM),
    parameter int TAG_WID      = 14,
    parameter int LINE_WORDS   = 8,
    parameter int OFF_WID      = clog2_min1(LINE_WORDS),
    parameter int DATA_WID     = 32,
    parameter bit WBACK_ENABLE = 1'b0,
    localparam int MA          = TAG_WID + ENTRYSEL_WID + OFF_WID
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            line_miss,
    input  logic                            replace_dirty,
    input  logic [TAG_WID-1:0]              address_tag,
    input  logic [ENTRYSEL_WID-1:0]         address_ent,
    input  logic [TAG_WID-1:0]              victim_tag,
    output logic                            line_refill,
    output logic [TAG_WID-1:0]              refill_tag,
    output logic                            writeback_ok,
    output logic                            busy,
    output logic [ENTRYSEL_WID+OFF_WID-1:0] cmem_addr,
    output logic                            cmem_re,
    output logic                            cmem_we,
    output logic [DATA_WID-1:0]             cmem_wdata,
    input  logic [DATA_WID-1:0]             cmem_rdata,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [MA-1:0]                   mem_addr,
    output logic [DATA_WID-1:0]             mem_wdata,
    input  logic [DATA_WID-1:0]             mem_rdata,
    input  logic                            mem_ack
);

    state_e                  state_q;
    logic [TAG_WID-1:0]      ctag_q;
    logic [TAG_WID-1:0]      vtag_q;
    logic [ENTRYSEL_WID-1:0] cent_q;
    logic [OFF_WID-1:0]      off_q;
    logic [DATA_WID-1:0]     wdata_q;
    logic                    wb_first_q;
    logic                    last_word;

    assign last_word = (off_q == OFF_WID'(LINE_WORDS - 1));

    // Sequencer: captures the miss, walks the line offsets, advances on mem_ack.
    // NOTE: async reset returns every register (and so every decoded output,
    // including mem_req) to idle immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ctag_q     <= '0;
            vtag_q     <= '0;
            cent_q     <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            wb_first_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees the
            // pre-edge values of the state and counters.
            case (state_q)
                ST_IDLE: begin
                    if (line_miss) begin
                        ctag_q  <= address_tag;
                        cent_q  <= address_ent;
                        vtag_q  <= victim_tag;
                        off_q   <= '0;
                        state_q <= (replace_dirty && WBACK_ENABLE) ? ST_WB_RD : ST_FILL;
                    end
                end
                ST_WB_RD: begin
                    wb_first_q <= 1'b1;
                    state_q    <= ST_WB_WR;
                end
                ST_WB_WR: begin
                    // Read data is only on cmem_rdata in the first WB_WR cycle;
                    // hold it so mem_wdata stays stable while the bus stalls.
                    wb_first_q <= 1'b0;
                    if (wb_first_q) wdata_q <= cmem_rdata;
                    if (mem_ack) begin
                        if (last_word) begin
                            state_q <= ST_WB_DONE;
                        end else begin
                            off_q   <= off_q + OFF_WID'(1);
                            state_q <= ST_WB_RD;
                        end
                    end
                end
                ST_WB_DONE: begin
                    off_q   <= '0;
                    state_q <= ST_FILL;
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        if (last_word) state_q <= ST_FILL_DONE;
                        else           off_q   <= off_q + OFF_WID'(1);
                    end
                end
                ST_FILL_DONE: state_q <= ST_IDLE;
                default:      state_q <= ST_IDLE;
            endcase
        end
    end

    // Output decode from registered state; only the fill write path follows mem_ack.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        line_refill  = 1'b0;
        refill_tag   = '0;
        writeback_ok = 1'b0;
        cmem_addr    = '0;
        cmem_re      = 1'b0;
        cmem_we      = 1'b0;
        cmem_wdata   = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state_q)
            ST_WB_RD: begin
                cmem_re   = 1'b1;
                cmem_addr = {cent_q, off_q};
            end
            ST_WB_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = MA'(word_addr(64'(vtag_q), 64'(cent_q), 64'(off_q),
                                          ENTRYSEL_WID, OFF_WID));
                mem_wdata = wb_first_q ? cmem_rdata : wdata_q;
            end
            ST_WB_DONE: writeback_ok = WBACK_ENABLE;
            ST_FILL: begin
                mem_req    = 1'b1;
                mem_addr   = MA'(word_addr(64'(ctag_q), 64'(cent_q), 64'(off_q),
                                           ENTRYSEL_WID, OFF_WID));
                cmem_addr  = {cent_q, off_q};
                cmem_we    = mem_ack;
                cmem_wdata = mem_ack ? mem_rdata : '0;
            end
            ST_FILL_DONE: begin
                line_refill = 1'b1;
                refill_tag  = ctag_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: one instance without writeback (a_*)
// and one with writeback enabled (b_*), each with a data RAM and bus model.
module tb_cache_refill_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Bus read data pattern and data RAM initial contents.
    function automatic logic [31:0] bus_data(input logic [20:0] a);
        return 32'hD000_0000 | {11'd0, a};
    endfunction
    function automatic logic [31:0] ram_init(input logic [6:0] i);
        return 32'hC0DE_0000 | {25'd0, i};
    endfunction

    // ---------------- instance A: WBACK_ENABLE = 0 ----------------
    logic        a_line_miss, a_dirty, a_line_refill, a_writeback_ok, a_busy;
    logic [13:0] a_tag, a_victim, a_refill_tag;
    logic [3:0]  a_ent;
    logic [6:0]  a_cmem_addr;
    logic        a_cmem_re, a_cmem_we, a_mem_req, a_mem_we, a_mem_ack, a_spur;
    logic [31:0] a_cmem_wdata, a_cmem_rdata, a_mem_wdata, a_mem_rdata;
    logic [20:0] a_mem_addr;
    logic [3:0]  a_cnt, a_delay;
    logic [31:0] a_cram [128];

    cache_refill_ctrl #(.WBACK_ENABLE(1'b0)) u_a (
        .clk(clk), .rst(rst), .line_miss(a_line_miss), .replace_dirty(a_dirty),
        .address_tag(a_tag), .address_ent(a_ent), .victim_tag(a_victim),
        .line_refill(a_line_refill), .refill_tag(a_refill_tag),
        .writeback_ok(a_writeback_ok), .busy(a_busy),
        .cmem_addr(a_cmem_addr), .cmem_re(a_cmem_re), .cmem_we(a_cmem_we),
        .cmem_wdata(a_cmem_wdata), .cmem_rdata(a_cmem_rdata),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack)
    );

    assign a_mem_ack   = a_spur | (a_mem_req && (a_cnt == a_delay));
    assign a_mem_rdata = bus_data(a_mem_addr);

    always @(posedge clk or negedge rst) begin
        if (!rst)                        a_cnt <= '0;
        else if (a_mem_req && !a_mem_ack) a_cnt <= a_cnt + 4'd1;
        else                             a_cnt <= '0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) a_cram[i] <= ram_init(7'(i));
            a_cmem_rdata <= '0;
        end else begin
            if (a_cmem_we) a_cram[a_cmem_addr] <= a_cmem_wdata;
            if (a_cmem_re) a_cmem_rdata <= a_cram[a_cmem_addr];
        end
    end

    // ---------------- instance B: WBACK_ENABLE = 1 ----------------
    logic        b_line_miss, b_dirty, b_line_refill, b_writeback_ok, b_busy;
    logic [13:0] b_tag, b_victim, b_refill_tag;
    logic [3:0]  b_ent;
    logic [6:0]  b_cmem_addr;
    logic        b_cmem_re, b_cmem_we, b_mem_req, b_mem_we, b_mem_ack;
    logic [31:0] b_cmem_wdata, b_cmem_rdata, b_mem_wdata, b_mem_rdata;
    logic [20:0] b_mem_addr;
    logic [31:0] b_cram [128];

    cache_refill_ctrl #(.WBACK_ENABLE(1'b1)) u_b (
        .clk(clk), .rst(rst), .line_miss(b_line_miss), .replace_dirty(b_dirty),
        .address_tag(b_tag), .address_ent(b_ent), .victim_tag(b_victim),
        .line_refill(b_line_refill), .refill_tag(b_refill_tag),
        .writeback_ok(b_writeback_ok), .busy(b_busy),
        .cmem_addr(b_cmem_addr), .cmem_re(b_cmem_re), .cmem_we(b_cmem_we),
        .cmem_wdata(b_cmem_wdata), .cmem_rdata(b_cmem_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack)
    );

    // Zero-wait bus for B.
    assign b_mem_ack   = b_mem_req;
    assign b_mem_rdata = bus_data(b_mem_addr);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) b_cram[i] <= ram_init(7'(i));
            b_cmem_rdata <= '0;
        end else begin
            if (b_cmem_we) b_cram[b_cmem_addr] <= b_cmem_wdata;
            if (b_cmem_re) b_cmem_rdata <= b_cram[b_cmem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int          cyc;
        int          word;
        logic        held_ok;
        logic        wb_seen;
        logic [20:0] exp_addr;

        a_line_miss = 0; a_dirty = 0; a_tag = '0; a_ent = '0; a_victim = '0;
        a_spur = 0; a_delay = 4'd0;
        b_line_miss = 0; b_dirty = 0; b_tag = '0; b_ent = '0; b_victim = '0;

        // ---- reset state ----
        #12;
        check("rst_a_busy",    64'(a_busy),        64'd0);
        check("rst_a_mem_req", 64'(a_mem_req),     64'd0);
        check("rst_a_refill",  64'(a_line_refill), 64'd0);
        check("rst_a_rtag",    64'(a_refill_tag),  64'd0);
        check("rst_a_cmem_we", 64'(a_cmem_we),     64'd0);
        check("rst_a_addr",    64'(a_mem_addr),    64'd0);
        check("rst_b_busy",    64'(b_busy),        64'd0);
        check("rst_b_wbok",    64'(b_writeback_ok), 64'd0);
        @(negedge clk);
        rst = 1;
        step;

        // ---- clean miss, zero-wait bus, tag 0x155 ent 3 ----
        a_tag = 14'h155; a_ent = 4'd3; a_victim = 14'h3FF; a_line_miss = 1;
        step;                                   // cycle 1: first FILL word
        a_line_miss = 0;
        for (int k = 0; k < 8; k++) begin
            exp_addr = {14'h155, 4'd3, 3'(k)};
            check("t1_mem_req",   64'(a_mem_req),    64'd1);
            check("t1_mem_we",    64'(a_mem_we),     64'd0);
            check("t1_mem_addr",  64'(a_mem_addr),   64'(exp_addr));
            check("t1_cmem_we",   64'(a_cmem_we),    64'd1);
            check("t1_cmem_addr", 64'(a_cmem_addr),  64'({4'd3, 3'(k)}));
            check("t1_cmem_wd",   64'(a_cmem_wdata), 64'(bus_data(exp_addr)));
            step;
        end
        check("t1_refill",  64'(a_line_refill), 64'd1);   // cycle 9
        check("t1_rtag",    64'(a_refill_tag),  64'h155);
        check("t1_req_off", 64'(a_mem_req),     64'd0);
        step;
        check("t1_refill_end", 64'(a_line_refill), 64'd0);
        check("t1_idle",       64'(a_busy),        64'd0);
        for (int k = 0; k < 8; k++)
            check("t1_ram", 64'(a_cram[{4'd3, 3'(k)}]), 64'(bus_data({14'h155, 4'd3, 3'(k)})));

        // ---- ack delayed 3 cycles per word, tag 0x2A3 ent 7 ----
        a_delay = 4'd3; a_tag = 14'h2A3; a_ent = 4'd7; a_line_miss = 1;
        step;
        a_line_miss = 0;
        cyc = 1; word = 0; held_ok = 1'b1;
        while (!a_line_refill && cyc < 200) begin
            if (!a_mem_req || a_mem_addr !== {14'h2A3, 4'd7, 3'(word)}) held_ok = 1'b0;
            if (a_mem_ack) word++;
            step;
            cyc++;
        end
        check("t2_fill_cycles", 64'(cyc),     64'd33);
        check("t2_words",       64'(word),    64'd8);
        check("t2_req_stable",  64'(held_ok), 64'd1);
        check("t2_rtag",        64'(a_refill_tag), 64'h2A3);
        step;
        a_delay = 4'd0;
        check("t2_ram0", 64'(a_cram[7'h38]), 64'(bus_data({14'h2A3, 4'd7, 3'd0})));
        check("t2_ram3", 64'(a_cram[7'h3B]), 64'(bus_data({14'h2A3, 4'd7, 3'd3})));
        check("t2_ram7", 64'(a_cram[7'h3F]), 64'(bus_data({14'h2A3, 4'd7, 3'd7})));

        // ---- spurious ack in IDLE, then dirty miss without writeback ----
        a_spur = 1;
        step;
        check("t5_spur_busy",  64'(a_busy),    64'd0);
        check("t5_spur_req",   64'(a_mem_req), 64'd0);
        check("t5_spur_cwe",   64'(a_cmem_we), 64'd0);
        step;
        a_spur = 0;
        a_tag = 14'h001; a_ent = 4'd0; a_victim = 14'h0AA; a_dirty = 1; a_line_miss = 1;
        step;
        check("t5_fill_req",  64'(a_mem_req),  64'd1);
        check("t5_fill_we",   64'(a_mem_we),   64'd0);
        check("t5_fill_addr", 64'(a_mem_addr), 64'({14'h001, 4'd0, 3'd0}));
        check("t5_no_rd",     64'(a_cmem_re),  64'd0);
        cyc = 1; wb_seen = 1'b0;
        while (!a_line_refill && cyc < 50) begin   // line_miss held high: ignored
            if (a_writeback_ok) wb_seen = 1'b1;
            step;
            cyc++;
        end
        a_line_miss = 0; a_dirty = 0;
        check("t5_cycles", 64'(cyc),     64'd9);
        check("t5_no_wb",  64'(wb_seen), 64'd0);
        step;
        check("t5_idle", 64'(a_busy), 64'd0);
        check("t5_ram7", 64'(a_cram[7'h07]), 64'(bus_data({14'h001, 4'd0, 3'd7})));

        // ---- dirty victim writeback on B: vtag 0x0AA ent 5, new tag 0x123 ----
        b_tag = 14'h123; b_ent = 4'd5; b_victim = 14'h0AA; b_dirty = 1; b_line_miss = 1;
        step;
        b_line_miss = 0; b_dirty = 0;
        for (int k = 0; k < 8; k++) begin
            check("t3_cmem_re",   64'(b_cmem_re),   64'd1);
            check("t3_cmem_addr", 64'(b_cmem_addr), 64'({4'd5, 3'(k)}));
            check("t3_rd_noreq",  64'(b_mem_req),   64'd0);
            step;
            check("t3_wr_req",   64'(b_mem_req),   64'd1);
            check("t3_wr_we",    64'(b_mem_we),    64'd1);
            check("t3_wr_addr",  64'(b_mem_addr),  64'({14'h0AA, 4'd5, 3'(k)}));
            check("t3_wr_data",  64'(b_mem_wdata), 64'(ram_init({4'd5, 3'(k)})));
            step;
        end
        check("t3_wbok",      64'(b_writeback_ok), 64'd1);
        check("t3_done_req",  64'(b_mem_req),      64'd0);
        step;
        check("t3_wbok_end",  64'(b_writeback_ok), 64'd0);
        check("t3_fill_we",   64'(b_mem_we),       64'd0);
        check("t3_fill_addr", 64'(b_mem_addr),     64'({14'h123, 4'd5, 3'd0}));
        repeat (8) step;
        check("t3_refill", 64'(b_line_refill), 64'd1);
        check("t3_rtag",   64'(b_refill_tag),  64'h123);
        step;
        check("t3_idle", 64'(b_busy), 64'd0);
        check("t3_ram0", 64'(b_cram[7'h28]), 64'(bus_data({14'h123, 4'd5, 3'd0})));
        check("t3_ram7", 64'(b_cram[7'h2F]), 64'(bus_data({14'h123, 4'd5, 3'd7})));

        // ---- async reset during fill word 4, then restart ----
        a_tag = 14'h0F0; a_ent = 4'd9; a_line_miss = 1;
        step;
        a_line_miss = 0;
        repeat (4) step;
        check("t4_word4", 64'(a_mem_addr), 64'({14'h0F0, 4'd9, 3'd4}));
        #2 rst = 0;
        #1;
        check("t4_rst_req",  64'(a_mem_req),     64'd0);
        check("t4_rst_busy", 64'(a_busy),        64'd0);
        check("t4_rst_cwe",  64'(a_cmem_we),     64'd0);
        @(negedge clk);
        rst = 1;
        step;
        check("t4_no_refill0", 64'(a_line_refill), 64'd0);
        step;
        check("t4_no_refill1", 64'(a_line_refill), 64'd0);
        a_line_miss = 1;
        step;
        a_line_miss = 0;
        check("t4_restart_addr", 64'(a_mem_addr), 64'({14'h0F0, 4'd9, 3'd0}));
        cyc = 1;
        while (!a_line_refill && cyc < 50) begin
            step;
            cyc++;
        end
        check("t4_cycles", 64'(cyc),          64'd9);
        check("t4_rtag",   64'(a_refill_tag), 64'h0F0);
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
